// File: rtl/axis_fifo.sv
// axis_fifo: AXI-stream FIFO with first-word-fall-through output, registered level and almost-full/empty flags.
module axis_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  parameter int AFULL_THRESH = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_vld,
  output logic             s_rdy,
  output logic [WIDTH-1:0] m_data,
  output logic             m_vld,
  input  logic             m_rdy,
  output logic [AW:0]      level,
  output logic             almost_full,
  output logic             almost_empty
);
  localparam logic [AW:0] L_AF = (AW+1)'(AFULL_THRESH);
  localparam logic [AW:0] L_AE = (AW+1)'(AEMPTY_THRESH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axis_fifo: DEPTH must be a power of 2 and >= 2");
  end
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd, r_level, w_level_n;
  logic r_s_rdy, r_af, r_ae, w_push, w_pop;
  assign w_push = s_vld & r_s_rdy;
  assign w_pop = m_vld & m_rdy;
  assign w_level_n = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign m_vld = r_wr != r_rd;
  assign m_data = r_mem[r_rd[AW-1:0]];
  assign s_rdy = r_s_rdy;
  assign level = r_level;
  assign almost_full = r_af;
  assign almost_empty = r_ae;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= s_data;
  end
  // s_rdy is computed from the next level so a pop on a full FIFO reopens the input one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_level <= '0;
      r_s_rdy <= 1'b0;
      r_af <= 1'b0;
      r_ae <= 1'b1;
    end else begin
      r_wr <= r_wr + (AW+1)'(w_push);
      r_rd <= r_rd + (AW+1)'(w_pop);
      r_level <= w_level_n;
      r_s_rdy <= w_level_n != L_FULL;
      r_af <= w_level_n >= L_AF;
      r_ae <= w_level_n <= L_AE;
    end
  end
endmodule
